// File: rtl/dino_pkg.sv
// Shared types for the dino sprite path: game-state encodings, sprite poses,
// screen limits and the per-pixel side-band struct carried down the render pipeline.
package dino_pkg;
  localparam int SPR_W_DEF = 32;
  localparam int SPR_H_DEF = 32;
  localparam int SCR_W     = 640;
  localparam int SCR_H     = 480;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0, ST_RUN = 4'd1, ST_JUMP = 4'd2, ST_DUCK = 4'd3, ST_DEAD = 4'd4
  } dino_state_e;

  typedef enum logic [2:0] {
    POSE_IDLE = 3'd0, POSE_RUN0 = 3'd1, POSE_RUN1 = 3'd2, POSE_JUMP = 3'd3,
    POSE_DUCK0 = 3'd4, POSE_DUCK1 = 3'd5, POSE_DEAD = 3'd6
  } pose_e;

  typedef struct packed {
    logic       inbox;
    logic       obs;
    logic [4:0] col;
  } pix_side_t;

  // Unknown game states fall back to the idle pose.
  function automatic pose_e pose_of(input logic [3:0] st, input logic anim);
    case (st)
      ST_RUN:  pose_of = anim ? POSE_RUN1 : POSE_RUN0;
      ST_JUMP: pose_of = POSE_JUMP;
      ST_DUCK: pose_of = anim ? POSE_DUCK1 : POSE_DUCK0;
      ST_DEAD: pose_of = POSE_DEAD;
      default: pose_of = POSE_IDLE;
    endcase
  endfunction
endpackage

// File: rtl/dino_sprite_render_if.sv
// Pixel-stream bundle between the VGA timing side (master) and the sprite renderer (slave).
interface dino_sprite_render_if;
  logic       frame_start;
  logic       pix_valid;
  logic [9:0] pix_x;
  logic [8:0] pix_y;
  logic       obs_on;
  logic       dino_on;
  logic       out_valid;

  modport master (output frame_start, pix_valid, pix_x, pix_y, obs_on,
                  input  dino_on, out_valid);
  modport slave  (input  frame_start, pix_valid, pix_x, pix_y, obs_on,
                  output dino_on, out_valid);
endinterface

// File: rtl/dino_sprite_render_hit.sv
// Per-frame overlap counter: closes each frame on frame_start and fires a one-shot kill.
module dino_sprite_render_hit #(
  parameter int HIT_MIN = 4
) (
  input  logic clk_25MHz,
  input  logic rst,
  input  logic frame_start,
  input  logic hit,
  input  logic armed,
  output logic kill,
  output logic collided
);
  logic [7:0] cnt, cnt_nx;
  logic       armed_q;

  // An overlap landing in the frame_start cycle still belongs to the closing frame.
  always_comb cnt_nx = (hit && cnt != 8'hFF) ? cnt + 8'd1 : cnt;

  always_ff @(posedge clk_25MHz) begin
    if (rst) begin
      cnt      <= '0;
      kill     <= 1'b0;
      collided <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      armed_q <= armed;
      kill    <= 1'b0;
      if (!armed) cnt <= '0;
      else if (frame_start) begin
        cnt <= '0;
        if (!collided && cnt_nx >= 8'(HIT_MIN)) begin
          kill     <= 1'b1;
          collided <= 1'b1;
        end
      end else cnt <= cnt_nx;
      // Disarming marks the start of a new game.
      if (armed_q && !armed) collided <= 1'b0;
    end
  end
endmodule

// File: rtl/dino_sprite_render.sv
// Dino sprite renderer: frame-latched position/pose, 2-cycle ROM lookup pipeline,
// and collision detection against the obstacle layer.
module dino_sprite_render
  import dino_pkg::*;
#(
  parameter int SPR_W   = SPR_W_DEF,
  parameter int SPR_H   = SPR_H_DEF,
  parameter int HIT_MIN = 4
) (
  input  logic                 clk_25MHz,
  input  logic                 rst,
  dino_sprite_render_if.slave  pix,
  input  logic [9:0]           dino_x,
  input  logic [8:0]           dino_y,
  input  logic [3:0]           dino_state,
  input  logic                 dino_anim,
  input  logic                 armed,
  output logic [7:0]           rom_addr,
  input  logic [SPR_W-1:0]     rom_data,
  output logic                 kill,
  output logic                 collided
);
  localparam int STAGES = 2;

  logic [9:0] lx;
  logic [8:0] ly;
  pose_e      lpose;
  logic       live;

  // Position and pose are frozen for a whole frame to avoid tearing.
  always_ff @(posedge clk_25MHz) begin
    if (rst) begin
      lx    <= '0;
      ly    <= '0;
      lpose <= POSE_IDLE;
      live  <= 1'b0;
    end else if (pix.frame_start) begin
      lx    <= dino_x;
      ly    <= dino_y;
      lpose <= pose_of(dino_state, dino_anim);
      live  <= 1'b1;
    end
  end

  logic [9:0] dx;
  logic [8:0] dy;
  pix_side_t  s0;

  // Unsigned wrap on dx/dy rejects pixels left of / above the sprite for free.
  always_comb begin
    dx       = pix.pix_x - lx;
    dy       = pix.pix_y - ly;
    s0.col   = dx[4:0];
    s0.obs   = pix.obs_on;
    s0.inbox = pix.pix_valid & live &
               (dx < 10'(SPR_W)) & (dy < 9'(SPR_H)) &
               (pix.pix_x < 10'(SCR_W)) & (pix.pix_y < 9'(SCR_H));
  end

  logic      [STAGES:1] vld_pipe;
  pix_side_t [STAGES:1] side_pipe;

  always_ff @(posedge clk_25MHz) begin
    if (rst) begin
      vld_pipe  <= '0;
      side_pipe <= '0;
      rom_addr  <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[STAGES-1:1], pix.pix_valid};
      side_pipe <= {side_pipe[STAGES-1:1], s0};
      rom_addr  <= {lpose, dy[4:0]};
    end
  end

  pix_side_t  s2;
  logic [4:0] bit_idx;
  logic       hit;

  // Bit 31 of the ROM row is the leftmost sprite pixel.
  assign s2            = side_pipe[STAGES];
  assign bit_idx       = 5'(SPR_W-1) - s2.col;
  assign pix.dino_on   = s2.inbox & rom_data[bit_idx];
  assign pix.out_valid = vld_pipe[STAGES];
  assign hit           = pix.out_valid & pix.dino_on & s2.obs & armed & (lpose != POSE_DEAD);

  dino_sprite_render_hit #(.HIT_MIN(HIT_MIN)) u_hit (
    .clk_25MHz   (clk_25MHz),
    .rst         (rst),
    .frame_start (pix.frame_start),
    .hit         (hit),
    .armed       (armed),
    .kill        (kill),
    .collided    (collided)
  );
endmodule

// File: tb/tb_dino_sprite_render.sv
// Directed bench for dino_sprite_render with a behavioural 1-cycle-latency sprite ROM.
module tb_dino_sprite_render;
  import dino_pkg::*;

  logic        clk_25MHz = 1'b0;
  logic        rst;
  logic [9:0]  dino_x;
  logic [8:0]  dino_y;
  logic [3:0]  dino_state;
  logic        dino_anim;
  logic        armed;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data;
  logic        kill;
  logic        collided;
  logic [31:0] rom_mem [256];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #20 clk_25MHz = ~clk_25MHz;

  dino_sprite_render_if pif ();

  dino_sprite_render #(.SPR_W(32), .SPR_H(32), .HIT_MIN(4)) dut (
    .clk_25MHz  (clk_25MHz),
    .rst        (rst),
    .pix        (pif),
    .dino_x     (dino_x),
    .dino_y     (dino_y),
    .dino_state (dino_state),
    .dino_anim  (dino_anim),
    .armed      (armed),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .kill       (kill),
    .collided   (collided)
  );

  always @(posedge clk_25MHz) rom_data <= rom_mem[rom_addr];

  // Called at a negedge; returns at the negedge where the pixel's output is due.
  task automatic drive_pix(input int x, input int y, input logic obs,
                           output logic on, output logic vld,
                           output logic vld_e, output logic [7:0] addr);
    pif.pix_x = 10'(x); pif.pix_y = 9'(y); pif.obs_on = obs; pif.pix_valid = 1'b1;
    @(negedge clk_25MHz);
    pif.pix_valid = 1'b0; pif.obs_on = 1'b0;
    vld_e = pif.out_valid; addr = rom_addr;
    @(negedge clk_25MHz);
    on = pif.dino_on; vld = pif.out_valid;
  endtask

  task automatic frame(output logic k1, output logic k2);
    pif.frame_start = 1'b1;
    @(negedge clk_25MHz);
    pif.frame_start = 1'b0; k1 = kill;
    @(negedge clk_25MHz);
    k2 = kill;
  endtask

  task automatic overlaps(input int n);
    logic on, v, ve; logic [7:0] a;
    for (int i = 0; i < n; i++) drive_pix(100 + i, 200 + i, 1'b1, on, v, ve, a);
  endtask

  task automatic test_reset();
    n_tests++; if (pif.dino_on !== 1'b0) begin n_fail++; $display("FAIL reset_dino_on got %b want 0", pif.dino_on); end
    n_tests++; if (pif.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", pif.out_valid); end
    n_tests++; if (kill !== 1'b0) begin n_fail++; $display("FAIL reset_kill got %b want 0", kill); end
    n_tests++; if (collided !== 1'b0) begin n_fail++; $display("FAIL reset_collided got %b want 0", collided); end
    n_tests++; if (rom_addr !== 8'h00) begin n_fail++; $display("FAIL reset_rom_addr got %h want 00", rom_addr); end
  endtask

  task automatic test_render();
    logic on, v, ve, k1, k2; logic [7:0] a;
    int pts [8][3] = '{'{99,200,0}, '{100,200,1}, '{131,200,1}, '{132,200,0},
                       '{100,199,0}, '{131,231,1}, '{131,232,0}, '{115,216,1}};
    int pat [4][2] = '{'{100,1}, '{101,0}, '{130,0}, '{131,1}};
    dino_x = 10'd100; dino_y = 9'd200; dino_state = ST_RUN; dino_anim = 1'b0;
    frame(k1, k2);
    drive_pix(110, 205, 1'b0, on, v, ve, a);
    n_tests++; if (ve !== 1'b0) begin n_fail++; $display("FAIL latency_1cyc out_valid got %b want 0", ve); end
    n_tests++; if (v !== 1'b1) begin n_fail++; $display("FAIL latency_2cyc out_valid got %b want 1", v); end
    n_tests++; if (a !== 8'h25) begin n_fail++; $display("FAIL render_rom_addr got %h want 25", a); end
    n_tests++; if (on !== 1'b1) begin n_fail++; $display("FAIL render_center got %b want 1", on); end
    foreach (pts[i]) begin
      drive_pix(pts[i][0], pts[i][1], 1'b0, on, v, ve, a);
      n_tests++;
      if (on !== 1'(pts[i][2]) || v !== 1'b1) begin
        n_fail++; $display("FAIL render_box (%0d,%0d) dino_on/out_valid got %b/%b want %0d/1",
                           pts[i][0], pts[i][1], on, v, pts[i][2]);
      end
    end
    rom_mem[8'h23] = 32'h8000_0001;
    foreach (pat[i]) begin
      drive_pix(pat[i][0], 203, 1'b0, on, v, ve, a);
      n_tests++;
      if (on !== 1'(pat[i][1])) begin
        n_fail++; $display("FAIL render_bitorder x=%0d got %b want %0d", pat[i][0], on, pat[i][1]);
      end
    end
    rom_mem[8'h23] = 32'hFFFF_FFFF;
  endtask

  task automatic test_pose();
    logic on, v, ve, k1, k2; logic [7:0] a;
    int tbl [7][3] = '{'{0,0,'h00}, '{1,1,'h40}, '{2,0,'h60}, '{3,0,'h80},
                       '{3,1,'hA0}, '{4,0,'hC0}, '{9,1,'h00}};
    foreach (tbl[i]) begin
      dino_state = 4'(tbl[i][0]); dino_anim = 1'(tbl[i][1]);
      frame(k1, k2);
      drive_pix(100, 200, 1'b0, on, v, ve, a);
      n_tests++;
      if (a !== 8'(tbl[i][2])) begin
        n_fail++; $display("FAIL pose_map state=%0d anim=%0d rom_addr got %h want %h",
                           tbl[i][0], tbl[i][1], a, 8'(tbl[i][2]));
      end
    end
    dino_state = ST_RUN; dino_anim = 1'b0;
    frame(k1, k2);
  endtask

  task automatic test_latch();
    logic on, v, ve, k1, k2; logic [7:0] a;
    dino_x = 10'd300;
    drive_pix(100, 200, 1'b0, on, v, ve, a);
    n_tests++; if (on !== 1'b1) begin n_fail++; $display("FAIL latch_old_pos got %b want 1", on); end
    drive_pix(300, 200, 1'b0, on, v, ve, a);
    n_tests++; if (on !== 1'b0) begin n_fail++; $display("FAIL latch_new_early got %b want 0", on); end
    frame(k1, k2);
    drive_pix(300, 200, 1'b0, on, v, ve, a);
    n_tests++; if (on !== 1'b1) begin n_fail++; $display("FAIL latch_new_pos got %b want 1", on); end
    drive_pix(100, 200, 1'b0, on, v, ve, a);
    n_tests++; if (on !== 1'b0) begin n_fail++; $display("FAIL latch_old_gone got %b want 0", on); end
  endtask

  task automatic test_clip();
    logic on, v, ve, k1, k2; logic [7:0] a;
    int pts [8][3] = '{'{620,470,1}, '{639,479,1}, '{639,470,1}, '{0,470,0},
                       '{19,470,0}, '{620,0,0}, '{620,9,0}, '{5,5,0}};
    dino_x = 10'd620; dino_y = 9'd470;
    frame(k1, k2);
    foreach (pts[i]) begin
      drive_pix(pts[i][0], pts[i][1], 1'b0, on, v, ve, a);
      n_tests++;
      if (on !== 1'(pts[i][2])) begin
        n_fail++; $display("FAIL clip (%0d,%0d) got %b want %0d", pts[i][0], pts[i][1], on, pts[i][2]);
      end
    end
    dino_x = 10'd100; dino_y = 9'd200;
    frame(k1, k2);
  endtask

  task automatic test_collision();
    logic on, v, ve, k1, k2; logic [7:0] a;
    armed = 1'b1; @(negedge clk_25MHz);
    frame(k1, k2);
    overlaps(3);
    drive_pix(50, 50, 1'b1, on, v, ve, a);
    frame(k1, k2);
    n_tests++; if (k1 !== 1'b0) begin n_fail++; $display("FAIL kill_3px got %b want 0", k1); end
    n_tests++; if (collided !== 1'b0) begin n_fail++; $display("FAIL collided_3px got %b want 0", collided); end
    overlaps(4);
    frame(k1, k2);
    n_tests++; if (k1 !== 1'b1) begin n_fail++; $display("FAIL kill_4px got %b want 1", k1); end
    n_tests++; if (k2 !== 1'b0) begin n_fail++; $display("FAIL kill_width got %b want 0", k2); end
    n_tests++; if (collided !== 1'b1) begin n_fail++; $display("FAIL collided_set got %b want 1", collided); end
    armed = 1'b0; @(negedge clk_25MHz);
    n_tests++; if (collided !== 1'b0) begin n_fail++; $display("FAIL collided_disarm got %b want 0", collided); end
    armed = 1'b1; @(negedge clk_25MHz);
    overlaps(4);
    frame(k1, k2);
    n_tests++; if (k1 !== 1'b1) begin n_fail++; $display("FAIL kill_rearm got %b want 1", k1); end
    overlaps(4);
    frame(k1, k2);
    n_tests++; if (k1 !== 1'b0) begin n_fail++; $display("FAIL kill_suppressed got %b want 0", k1); end
    n_tests++; if (collided !== 1'b1) begin n_fail++; $display("FAIL collided_sticky got %b want 1", collided); end
  endtask

  task automatic test_dead_unarmed();
    logic on, v, ve, k1, k2; logic [7:0] a;
    armed = 1'b0; @(negedge clk_25MHz);
    armed = 1'b1; @(negedge clk_25MHz);
    dino_state = ST_DEAD;
    frame(k1, k2);
    drive_pix(100, 200, 1'b1, on, v, ve, a);
    n_tests++; if (on !== 1'b1) begin n_fail++; $display("FAIL dead_drawn got %b want 1", on); end
    overlaps(4);
    frame(k1, k2);
    n_tests++; if (k1 !== 1'b0) begin n_fail++; $display("FAIL kill_dead got %b want 0", k1); end
    dino_state = ST_RUN;
    frame(k1, k2);
    armed = 1'b0;
    overlaps(5);
    frame(k1, k2);
    n_tests++; if (k1 !== 1'b0) begin n_fail++; $display("FAIL kill_unarmed got %b want 0", k1); end
    armed = 1'b1; @(negedge clk_25MHz);
    frame(k1, k2);
    overlaps(4);
    frame(k1, k2);
    n_tests++; if (collided !== 1'b1) begin n_fail++; $display("FAIL collided_before_rst got %b want 1", collided); end
  endtask

  task automatic test_reset_mid();
    logic on, v, ve, k1, k2; logic [7:0] a;
    pif.pix_y = 9'd200; pif.pix_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin pif.pix_x = 10'(100 + i); @(negedge clk_25MHz); end
    n_tests++; if (pif.dino_on !== 1'b1) begin n_fail++; $display("FAIL pre_rst_stream got %b want 1", pif.dino_on); end
    rst = 1'b1; pif.pix_x = 10'd103; @(negedge clk_25MHz);
    n_tests++;
    if ({pif.dino_on, pif.out_valid, kill, collided} !== 4'b0000 || rom_addr !== 8'h00) begin
      n_fail++; $display("FAIL rst_mid on/vld/kill/coll got %b%b%b%b addr %h want 0000 addr 00",
                         pif.dino_on, pif.out_valid, kill, collided, rom_addr);
    end
    rst = 1'b0; pif.pix_x = 10'd104; @(negedge clk_25MHz);
    n_tests++; if (pif.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_release_vld1 got %b want 0", pif.out_valid); end
    pif.pix_x = 10'd105; @(negedge clk_25MHz);
    n_tests++; if (pif.out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_release_vld2 got %b want 1", pif.out_valid); end
    n_tests++; if (pif.dino_on !== 1'b0) begin n_fail++; $display("FAIL rst_no_render got %b want 0", pif.dino_on); end
    pif.pix_valid = 1'b0;
    repeat (2) @(negedge clk_25MHz);
    frame(k1, k2);
    drive_pix(100, 200, 1'b0, on, v, ve, a);
    n_tests++; if (on !== 1'b1) begin n_fail++; $display("FAIL rst_resume got %b want 1", on); end
  endtask

  initial begin
    rst = 1'b1;
    pif.frame_start = 1'b0; pif.pix_valid = 1'b0; pif.pix_x = '0; pif.pix_y = '0; pif.obs_on = 1'b0;
    dino_x = '0; dino_y = '0; dino_state = ST_IDLE; dino_anim = 1'b0; armed = 1'b0;
    foreach (rom_mem[i]) rom_mem[i] = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk_25MHz);
    test_reset();
    rst = 1'b0;
    @(negedge clk_25MHz);
    test_render();
    test_pose();
    test_latch();
    test_clip();
    test_collision();
    test_dead_unarmed();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
